// File: rtl/inst_encoder_pkg.sv
// Shared definitions for the instruction encoder and the core's immediate
// generator: format codes, opcode field positions and immediate limits.
package inst_encoder_pkg;

  // Immediate format selected by opcode[6:5]: 00 -> I, 01 -> S, 1x -> B.
  typedef enum logic [1:0] {
    FMT_I = 2'd0,
    FMT_S = 2'd1,
    FMT_B = 2'd2
  } fmt_e;

  // Opcode bits that select the immediate format.
  localparam int OPC_FMT_HI = 6;
  localparam int OPC_FMT_LO = 5;

  // Signed immediate ranges.  B immediates are byte offsets and must be even.
  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;

  function automatic fmt_e fmt_of(input logic [1:0] sel);
    fmt_e f;
    if (sel[1])      f = FMT_B;
    else if (sel[0]) f = FMT_S;
    else             f = FMT_I;
    return f;
  endfunction

endpackage

// File: rtl/enc_skid_buf.sv
// Two-entry FIFO output buffer for the instruction encoder.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   i_push, i_data write one entry (ignored when full)
//   i_pop          consumer takes the head entry (ignored when empty)
//   o_valid        head entry present
//   o_data         head entry; RESET_VAL after reset
//   o_count        occupancy 0..2 (also serves as the debug view of state)
// Handshake: an entry moves when valid and ready are both high at a rising
// edge; o_data is held stable while o_valid is high and it is not popped.
module enc_skid_buf #(
  parameter int W = 40,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [0:1];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_count;

  logic w_push;
  logic w_pop;

  assign w_push = i_push && (r_count != 2'd2);
  assign w_pop  = i_pop && (r_count != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= RESET_VAL;
      r_mem[1] <= RESET_VAL;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder: packs decoded instruction fields back into a 32-bit
// word (inverse of the immediate generator), range-checks the immediate,
// tags each good word with a sequential instruction-memory word address and
// queues it in a two-entry output buffer.
// Ports:
//   clk, rst                synchronous active-high reset
//   in_valid / in_ready     field bundle handshake
//   in_opcode, in_funct3, in_rd, in_rs1, in_rs2, in_imm   instruction fields
//   out_valid / out_ready   encoded word handshake
//   out_inst, out_addr      encoded word and its word address
//   err_pulse               one cycle after an accepted bundle is rejected
//   err_count               saturating reject count
// Handshake: a transfer happens when valid and ready are both high at a
// rising edge.  in_ready comes from registered occupancy only.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_pulse,
  output logic [7:0]        err_count
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  fmt_e               w_fmt;
  logic [31:0]        w_inst;
  logic               w_in_range;
  logic               w_accept;
  logic               w_push;
  logic               w_reject;
  logic [1:0]         w_count;
  logic [31+ADDR_W:0] w_buf_data;

  logic [ADDR_W-1:0]  r_addr;
  logic               r_err_pulse;
  logic [7:0]         r_err_count;

  assign w_fmt = fmt_of(in_opcode[OPC_FMT_HI:OPC_FMT_LO]);

  always_comb begin
    w_inst     = '0;
    w_in_range = 1'b0;
    case (w_fmt)
      FMT_I: begin
        w_inst     = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        w_in_range = ($signed(in_imm) >= IMM12_MIN) && ($signed(in_imm) <= IMM12_MAX);
      end
      FMT_S: begin
        w_inst     = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        w_in_range = ($signed(in_imm) >= IMM12_MIN) && ($signed(in_imm) <= IMM12_MAX);
      end
      default: begin
        // imm[0] is implied zero in a branch offset, so odd offsets are rejected.
        w_inst     = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                      in_imm[4:1], in_imm[11], in_opcode};
        w_in_range = ($signed(in_imm) >= IMM13_MIN) && ($signed(in_imm) <= IMM13_MAX)
                     && !in_imm[0];
      end
    endcase
  end

  assign in_ready   = (w_count != 2'd2);
  assign w_accept   = in_valid && in_ready;
  assign w_push     = w_accept && w_in_range;
  assign w_reject   = w_accept && !w_in_range;
  // Address is bound to the word when it enters the buffer.
  assign w_buf_data = {w_inst, r_addr};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= BASE;
      r_err_pulse <= 1'b0;
      r_err_count <= 8'd0;
    end else begin
      if (w_push) begin
        r_addr <= r_addr + 1'b1;
      end
      r_err_pulse <= w_reject;
      if (w_reject && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  enc_skid_buf #(
    .W         (32 + ADDR_W),
    .RESET_VAL ({32'd0, BASE})
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_buf_data),
    .i_pop   (out_ready),
    .o_valid (out_valid),
    .o_data  ({out_inst, out_addr}),
    .o_count (w_count)
  );

  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;

endmodule
